// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: instruction field positions, the canonical NOP
// and the fetch-stage state encoding.
package fetch_stage_pkg;

  localparam int OP_W  = 6;
  localparam int REG_W = 5;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, synchronous IMEM addressing, IF/ID
// pipeline register and stall/flush performance counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PC_WriteEn,
  input  logic             IFID_WriteEn,
  input  logic             Flush,
  input  logic [31:0]      Redirect_PC,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IFID_Instr,
  output logic [31:0]      IFID_PC4,
  output logic             IFID_Valid,
  output logic [OP_W-1:0]  ID_Op,
  output logic [REG_W-1:0] ID_rs,
  output logic [REG_W-1:0] ID_rt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fetch_state_t state_q;
  logic [31:0]  pc_q, pc_d, pc_plus4;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         run, stall_inc, flush_inc;

  assign run       = (state_q == RUN);
  assign pc_plus4  = pc_q + 32'd4;
  assign stall_inc = run && !PC_WriteEn;
  assign flush_inc = run && Flush && PC_WriteEn;

  // IMEM latches pc_d on the same edge pc_q does, so imem_rdata always
  // belongs to pc_q; a held PC simply re-reads the same word.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (run && PC_WriteEn) begin
      pc_d = Flush ? (Redirect_PC & 32'hFFFF_FFFC) : pc_plus4;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!run || (IFID_WriteEn && Flush && PC_WriteEn)) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (IFID_WriteEn) begin
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= RUN;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr  = pc_d;
  assign IFID_Instr = instr_q;
  assign IFID_PC4   = pc4_q;
  assign IFID_Valid = valid_q;
  assign ID_Op      = instr_q[OP_HI:OP_LO];
  assign ID_rs      = instr_q[RS_HI:RS_LO];
  assign ID_rt      = instr_q[RT_HI:RT_LO];

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS-style pipeline: owns the PC register, drives the synchronous instruction memory, and holds the IF/ID pipeline register. It sits directly upstream of the load-use stall controller. It consumes that controller's `PC_WriteEn`/`IFID_WriteEn` and produces the `ID_Op`/`ID_rs`/`ID_rt` fields the controller compares against `EX_rt`. It also accepts taken-branch/jump redirects from ID and keeps stall/flush performance counters.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first instruction fetched after reset; bits [1:0] must be 0.
- `CNT_W`, default 16: width of the saturating performance counters.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `PC_WriteEn` in 1: 1 = PC may advance; from the stall controller.
- `IFID_WriteEn` in 1: 1 = IF/ID may load; from the stall controller.
- `Flush` in 1: taken branch/jump resolved in ID this cycle.
- `Redirect_PC` in 32: target address; valid when `Flush`=1.
- `imem_addr` out 32: byte address presented to the synchronous IMEM, which latches it on the clock edge.
- `imem_rdata` in 32: IMEM output; the word at the address latched on the previous edge.
- `IFID_Instr` out 32: registered instruction.
- `IFID_PC4` out 32: registered PC+4 of that instruction.
- `IFID_Valid` out 1: 0 = bubble.
- `ID_Op` out 6: `IFID_Instr[31:26]`.
- `ID_rs` out 5: `IFID_Instr[25:21]`.
- `ID_rt` out 5: `IFID_Instr[20:16]`.
- `stall_cnt` out CNT_W: saturating count of RUN cycles with `PC_WriteEn`=0.
- `flush_cnt` out CNT_W: saturating count of honoured flushes.

## Operation
- Address alignment: `imem_rdata` always corresponds to `pc_q`, because `imem_addr` = `pc_next`, the value `pc_q` takes at the next edge.
- FSM states: BOOT and RUN.
  - Reset enters BOOT.
  - BOOT → RUN unconditionally after one cycle.
  - RUN is held until reset.
- BOOT behaviour:
  - `pc_next` = `pc_q` = RESET_PC, so IMEM latches RESET_PC.
  - IF/ID loads a bubble.
  - Inputs are ignored and counters are frozen.
- RUN, `pc_next` priority:
  - `PC_WriteEn`=0: `pc_q`, i.e. hold. IMEM re-reads the same word, so no hold buffer is needed.
  - Else `Flush`=1: `{Redirect_PC[31:2],2'b00}`.
  - Else: `pc_q+4`, wrapping modulo 2^32.
- RUN, IF/ID update:
  - `IFID_WriteEn`=0: hold all IF/ID fields.
  - Else `Flush`=1 and `PC_WriteEn`=1: bubble, i.e. `Instr`=0 (NOP), `PC4`=0, `Valid`=0.
  - Else: `{imem_rdata, pc_q+4, 1}`.
- Stall priority: a flush asserted while `PC_WriteEn`=0 is ignored. The branch in ID is itself stalled and re-asserts `Flush` when it resolves.
- Split enables: `PC_WriteEn` and `IFID_WriteEn` are applied independently. Unequal combinations are legal and each register obeys its own enable.
- Counters:
  - `stall_cnt` increments when RUN and `PC_WriteEn`=0.
  - `flush_cnt` increments when RUN, `Flush`=1 and `PC_WriteEn`=1.
  - Both saturate at all-ones.

## Timing
- Reset values:
  - `pc_q`=RESET_PC and state=BOOT.
  - `IFID_Instr`=0, `IFID_PC4`=0, `IFID_Valid`=0.
  - Counters 0.
  - `imem_addr`=RESET_PC, `ID_*`=0.
- Boot latency:
  - Edge 1 after `rst_n` rises: BOOT → RUN, and IMEM latches RESET_PC.
  - Edge 2: IF/ID holds `{instr@RESET_PC, RESET_PC+4, 1}`.
  - First valid instruction in ID is therefore 2 cycles after reset release.
- Fetch throughput: one instruction per cycle when unstalled.
- Branch penalty: exactly one bubble. At the edge that samples `Flush`=1, IF/ID is bubbled and `pc_q` becomes the target. At the next edge IF/ID holds the target instruction.
- Stall: with `PC_WriteEn`=`IFID_WriteEn`=0 for N cycles, `pc_q`, `imem_addr` and IF/ID are held for N cycles, with no instruction loss or duplication.
- Reset mid-operation: asynchronous return to the reset values; the next release repeats the BOOT sequence.
- `ID_*` outputs are pure slices of the IF/ID register, with no added latency.

## Structure
- Shared pipeline package holds:
  - `OP_W`=6 and `REG_W`=5.
  - Field bit positions (OP_HI/LO, RS_HI/LO, RT_HI/LO).
  - `NOP_INSTR`=32'h0.
  - The `fetch_state_t` enum {BOOT, RUN}.
- One sub-module, `sat_counter` (parameter W; ports: clk, rst_n, inc, count), instantiated twice.

## Test plan
- Reset release with RESET_PC=0x100 and IMEM[0x100]=0x8C220004: edge 2 gives `IFID_Instr`=0x8C220004, `IFID_PC4`=0x104, `IFID_Valid`=1, `ID_Op`=0x23, `ID_rs`=1, `ID_rt`=2.
- Straight-line fetch from 0x0 for 8 cycles: `IFID_PC4` steps 0x4, 0x8, … 0x20, and each instruction appears exactly once.
- Both enables low for 3 cycles at `pc_q`=0x10: `imem_addr`=0x10 and IF/ID frozen for 3 cycles, `stall_cnt`=3, and the next instruction is from 0x10.
- `Flush`=1 with `Redirect_PC`=0x203 at `pc_q`=0x20: next edge gives a bubble and `pc_q`=0x200; the following edge gives the instr@0x200 with `IFID_PC4`=0x204; `flush_cnt`=1.
- `Flush`=1 while `PC_WriteEn`=0: no redirect and `flush_cnt` unchanged. `Flush` held into the next unstalled cycle is then honoured.
- `rst_n` pulsed low mid-run: all outputs return to reset values immediately; the BOOT sequence repeats. Separately, force `stall_cnt` near max with CNT_W=4: it stops at 15.
